frame_serializer: RTL and testbench
===================================

// Module: frame_serializer
// PURPOSE
// - Output-side companion to averaging_filter: takes one whole filtered frame (R_I x C_I x W_I,
//   parallel) through a valid/ready load handshake.
// - Emits the frame one pixel per beat, raster order, on a valid/ready stream toward the display/UART path.
// - One frame is in flight at a time. The captured frame is held internally, so the filter output may change after load.
// PARAMETERS
// - R_I  5  image rows
// - C_I  5  image columns
// - W_I  8  pixel width in bits
// - RW   $clog2(R_I) (min 1)  row index width (localparam)
// - CW   $clog2(C_I) (min 1)  column index width (localparam)
// PORTS
// - clk      in   1            system clock, all logic on posedge
// - rst      in   1            synchronous reset, active-high
// - cen      in   1            clock enable; 0 freezes all state and outputs
// - s_valid  in   1            load request, s_img valid
// - s_ready  out  1            serializer idle, can accept a frame
// - s_img    in   R_I*C_I*W_I  frame, packed [R_I-1:0][C_I-1:0][W_I-1:0]
// - m_valid  out  1            output pixel valid
// - m_ready  in   1            downstream accepts pixel
// - m_data   out  W_I          pixel value
// - m_row    out  RW           row index of m_data
// - m_col    out  CW           column index of m_data
// - m_last   out  1            final beat of the frame
// - busy     out  1            frame being streamed (= !s_ready)
// BEHAVIOUR
// - Clock/reset: one clock, clk. rst is synchronous and active-high, and overrides cen.
// - Reset values: state=IDLE, s_ready=1, m_valid=0, m_data=0, m_row=0, m_col=0, m_last=0, busy=0, frame reg=0.
// - States:
//   - IDLE: s_ready=1, m_valid=0.
//     - On posedge with cen & s_valid: capture s_img, set r=0/c=0, go to STREAM.
//   - STREAM: m_valid=1, m_data=frame[r][c], m_row=r, m_col=c, s_ready=0.
//   - Beat = posedge with cen & m_valid & m_ready.
//     - On a beat: c++. If c==C_I-1, then c=0 and r++.
//     - m_last = (r==R_I-1 && c==C_I-1), without CHK.
//     - A beat with m_last set returns to IDLE.
// - Latency:
//   - The first pixel is valid the cycle after load acceptance.
//   - s_ready rises the cycle after the last beat.
//   - There is no idle gap between beats while m_ready=1.
// - Frame length: exactly R_I*C_I beats. Full-throughput streaming takes R_I*C_I cycles.
// - Backpressure: while m_valid & !m_ready, hold m_data/m_row/m_col/m_last stable. m_valid must not drop.
// - cen=0:
//   - No capture, no beat, no state change. Outputs hold.
//   - A handshake with cen=0 does not count.
// - s_valid during STREAM is ignored (s_ready=0). No frame is lost or queued.
// - Reset mid-frame: abort immediately to IDLE. Discard the remaining pixels; m_valid=0 next cycle.
// - Arithmetic: indices are unsigned and saturate-free. Wrap is defined only by the rules above.
// CONFIGURATION
// - Macro FRAME_CHECKSUM_EN.
// - Defined:
//   - After pixel (R_I-1,C_I-1), add state CHK with one extra beat.
//   - CHK beat: m_data = sum of all R_I*C_I pixels mod 2^W_I, m_row=R_I-1, m_col=C_I-1.
//   - m_last is asserted only on the CHK beat, not on the last pixel.
//   - Frame length = R_I*C_I+1 beats.
//   - The sum accumulates on pixel beats and is cleared at load and at reset.
// - Undefined: no CHK state, no accumulator. Behaviour is as in BEHAVIOUR.
// TESTING
// - Reset, then an idle cycle -> s_ready=1, m_valid=0, m_data=0, busy=0.
// - Load img[r][c]=r*C_I+c (0..24), m_ready=1:
//   - m_data is 0,1,...,24 on consecutive cycles, starting 1 cycle after load.
//   - m_last only with data 24 at (4,4).
//   - s_ready=1 the next cycle.
// - Same frame, m_ready toggling 1,0,1,0:
//   - Data is held across stalls.
//   - 25 beats are delivered in order, with no duplicates and no skips.
// - Pulse s_valid with a different frame during beat 10 -> ignored. The stream finishes the original 0..24.
// - Assert rst at beat 7 (data 7) -> m_valid=0 next cycle, s_ready=1. A new load restarts at (0,0).
// - cen=0 for 3 cycles mid-frame (m_ready=1) -> no index advance, outputs constant. The stream resumes afterward.
// - FRAME_CHECKSUM_EN, all pixels 8'hFF:
//   - 26th beat carries m_data = 25*255 mod 256 = 8'hE7, with m_last=1.
//   - Beat 25 has m_last=0.

Source files
------------

// File: rtl/frame_serializer.sv
// Captures one R_I x C_I frame over a load handshake and streams it out one pixel per beat in raster order.
// Define FRAME_CHECKSUM_EN to append a checksum beat (sum of all pixels mod 2^W_I) after the last pixel.
module frame_serializer #(
    parameter int R_I = 5,
    parameter int C_I = 5,
    parameter int W_I = 8,
    localparam int RW = (R_I > 1) ? $clog2(R_I) : 1,
    localparam int CW = (C_I > 1) ? $clog2(C_I) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cen,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [R_I-1:0][C_I-1:0][W_I-1:0] s_img,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [W_I-1:0]               m_data,
    output logic [RW-1:0]                m_row,
    output logic [CW-1:0]                m_col,
    output logic                         m_last,
    output logic                         busy
);

    localparam logic [RW-1:0] RMAX = RW'(R_I - 1);
    localparam logic [CW-1:0] CMAX = CW'(C_I - 1);

`ifdef FRAME_CHECKSUM_EN
    typedef enum logic [1:0] {IDLE, STREAM, CHK} state_t;
`else
    typedef enum logic [1:0] {IDLE, STREAM} state_t;
`endif

    state_t state, next;

    logic [R_I-1:0][C_I-1:0][W_I-1:0] frame;
    logic [RW-1:0] r;
    logic [CW-1:0] c;
    logic          load;
    logic          beat;
    logic          at_end;

`ifdef FRAME_CHECKSUM_EN
    logic [W_I-1:0] sum;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= next;
    end

    // Outputs are decoded from the held state and indices, so a stall or cen=0 keeps them stable.
    always_comb begin
        next    = state;
        s_ready = 1'b0;
        m_valid = 1'b0;
        m_data  = '0;
        m_row   = '0;
        m_col   = '0;
        m_last  = 1'b0;
        load    = 1'b0;
        beat    = 1'b0;
        at_end  = (r == RMAX) && (c == CMAX);
        case (state)
            IDLE: begin
                s_ready = 1'b1;
                if (cen && s_valid) begin
                    load = 1'b1;
                    next = STREAM;
                end
            end
            STREAM: begin
                m_valid = 1'b1;
                m_data  = frame[r][c];
                m_row   = r;
                m_col   = c;
                beat    = cen && m_ready;
`ifdef FRAME_CHECKSUM_EN
                if (beat && at_end)
                    next = CHK;
`else
                m_last = at_end;
                if (beat && at_end)
                    next = IDLE;
`endif
            end
`ifdef FRAME_CHECKSUM_EN
            CHK: begin
                m_valid = 1'b1;
                m_data  = sum;
                m_row   = RMAX;
                m_col   = CMAX;
                m_last  = 1'b1;
                if (cen && m_ready)
                    next = IDLE;
            end
`endif
            default: next = IDLE;
        endcase
    end

    // Indices return to (0,0) after the last pixel so they never address past the frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame <= '0;
            r     <= '0;
            c     <= '0;
`ifdef FRAME_CHECKSUM_EN
            sum   <= '0;
`endif
        end else if (load) begin
            frame <= s_img;
            r     <= '0;
            c     <= '0;
`ifdef FRAME_CHECKSUM_EN
            sum   <= '0;
`endif
        end else if (beat) begin
            if (at_end) begin
                r <= '0;
                c <= '0;
            end else if (c == CMAX) begin
                r <= r + RW'(1);
                c <= '0;
            end else begin
                c <= c + CW'(1);
            end
`ifdef FRAME_CHECKSUM_EN
            sum <= sum + frame[r][c];
`endif
        end
    end

    assign busy = !s_ready;

endmodule

// File: tb/tb_frame_serializer.sv
// Directed bench for frame_serializer: full-rate, stalled, ignored-load, reset-abort and cen-freeze streams.
// Expected beats come from the bench's own pixel table; FRAME_CHECKSUM_EN adds the checksum beat.
module tb_frame_serializer;

`ifdef FRAME_CHECKSUM_EN
    localparam int NB = 26;
`else
    localparam int NB = 25;
`endif

    logic                  clk;
    logic                  rst;
    logic                  cen;
    logic                  s_valid;
    logic                  s_ready;
    logic [4:0][4:0][7:0]  s_img;
    logic                  m_valid;
    logic                  m_ready;
    logic [7:0]            m_data;
    logic [2:0]            m_row;
    logic [2:0]            m_col;
    logic                  m_last;
    logic                  busy;

    logic [7:0]            expPix [25];
    int                    nCompared;
    int                    nMismatched;

    frame_serializer dut (
        .clk     (clk),
        .rst     (rst),
        .cen     (cen),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_img   (s_img),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_row   (m_row),
        .m_col   (m_col),
        .m_last  (m_last),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        nCompared++;
        if (got !== want) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic vRst, input logic vCen, input logic vSv, input logic vMr);
        rst     = vRst;
        cen     = vCen;
        s_valid = vSv;
        m_ready = vMr;
    endtask

    // Fill the expected table with either the ramp r*5+c or a constant, and drive it onto s_img.
    task automatic setFrame(input bit ramp, input logic [7:0] value);
        for (int i = 0; i < 25; i++) begin
            expPix[i] = ramp ? 8'(i) : value;
            s_img[i / 5][i % 5] = expPix[i];
        end
    endtask

    task automatic loadFrame();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        #1;
        checkOutput("s_ready_before_load", s_ready, 1);
        tick();
        s_valid = 1'b0;
    endtask

    // mode 0: m_ready=1; 1: m_ready toggles; 2: s_valid pulse at beat 10; 3: cen low 3 cycles at beat 12
    task automatic streamCheck(input int mode);
        int k, cyc, cenLow;
        bit stalled;
        logic [7:0] prevData, sumModel, expData;
        logic [2:0] prevRow, prevCol, expRow, expCol;
        logic prevLast;
        k = 0; cyc = 0; cenLow = 0; stalled = 0;
        prevData = '0; prevRow = '0; prevCol = '0; prevLast = 1'b0;
        sumModel = '0;
        for (int i = 0; i < 25; i++) sumModel = sumModel + expPix[i];
        while (k < NB && cyc < 400) begin
            m_ready = (mode == 1) ? ((cyc % 2) == 0) : 1'b1;
            cen     = 1'b1;
            s_valid = 1'b0;
            if (mode == 3 && k == 12 && cenLow < 3) begin
                cen = 1'b0;
                cenLow++;
            end
            if (mode == 2 && k == 10) begin
                s_valid = 1'b1;
                for (int i = 0; i < 25; i++) s_img[i / 5][i % 5] = 8'hAA;
            end
            #1;
            checkOutput("m_valid_stream", m_valid, 1);
            checkOutput("busy_stream", busy, 1);
            if (s_valid) checkOutput("s_ready_while_busy", s_ready, 0);
            if (stalled) begin
                checkOutput("hold_data", m_data, prevData);
                checkOutput("hold_row", m_row, prevRow);
                checkOutput("hold_col", m_col, prevCol);
                checkOutput("hold_last", m_last, prevLast);
            end
            if (m_ready && cen) begin
                if (k < 25) begin
                    expData = expPix[k];
                    expRow  = 3'(k / 5);
                    expCol  = 3'(k % 5);
                end else begin
                    expData = sumModel;
                    expRow  = 3'd4;
                    expCol  = 3'd4;
                end
                checkOutput($sformatf("beat%0d_data", k), m_data, expData);
                checkOutput($sformatf("beat%0d_row", k), m_row, expRow);
                checkOutput($sformatf("beat%0d_col", k), m_col, expCol);
                checkOutput($sformatf("beat%0d_last", k), m_last, (k == NB - 1));
                k++;
                stalled = 0;
            end else begin
                stalled = 1;
            end
            prevData = m_data; prevRow = m_row; prevCol = m_col; prevLast = m_last;
            tick();
            cyc++;
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("beat_count", k, NB);
        checkOutput("s_ready_after_frame", s_ready, 1);
        checkOutput("m_valid_after_frame", m_valid, 0);
    endtask

    initial begin
        nCompared   = 0;
        nMismatched = 0;
        s_img       = '0;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        checkOutput("reset_s_ready", s_ready, 1);
        checkOutput("reset_m_valid", m_valid, 0);
        checkOutput("reset_m_data", m_data, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_m_last", m_last, 0);

        $display("[TB] full-rate ramp frame");
        setFrame(1'b1, 8'h00);
        loadFrame();
        streamCheck(0);

        $display("[TB] m_ready toggling");
        setFrame(1'b1, 8'h00);
        loadFrame();
        streamCheck(1);

        $display("[TB] s_valid pulse during stream");
        setFrame(1'b1, 8'h00);
        loadFrame();
        streamCheck(2);

        $display("[TB] cen held low mid-frame");
        setFrame(1'b1, 8'h00);
        loadFrame();
        streamCheck(3);

        $display("[TB] reset at beat 7");
        setFrame(1'b1, 8'h00);
        loadFrame();
        m_ready = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        checkOutput("pre_reset_data", m_data, 7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_ready = 1'b0;
        checkOutput("abort_m_valid", m_valid, 0);
        checkOutput("abort_s_ready", s_ready, 1);
        checkOutput("abort_m_data", m_data, 0);
        setFrame(1'b1, 8'h00);
        loadFrame();
        checkOutput("restart_row", m_row, 0);
        checkOutput("restart_col", m_col, 0);
        streamCheck(0);

        $display("[TB] all-0xFF frame");
        setFrame(1'b0, 8'hFF);
        loadFrame();
        streamCheck(0);

        $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
